conv_row_feeder: RTL and testbench

//  Upstream stage of the convolution top. Buffers one D x H x W feature map streamed
//  in one pixel per cycle. It then replays that map as zero-padded 3-row windows
//  (rows r-1, r, r+1) on image0/1/2, one window per (output row, input channel).

---
 rtl/conv_row_feeder.sv | 185 ++++++++++++++++++
 tb/tb_conv_row_feeder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_row_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : conv_row_feeder
//  Description : Buffers one D x H x W feature map streamed one pixel per
//                cycle and replays it as zero-padded 3-row windows
//                (rows r-1, r, r+1) per (output row, channel). Each window
//                is announced by image_start_o and held until conv_done_i.
//                Optional macro CONV_FEEDER_STATUS_EN adds the row_idx_o,
//                ch_idx_o and sticky ovf_o status ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_row_feeder #(
   parameter  int D          = 4,
   parameter  int H          = 6,
   parameter  int W          = 6,
   parameter  int DATA_WIDTH = 8,
   localparam int RW         = (H > 1) ? $clog2(H) : 1,
   localparam int CW         = (D > 1) ? $clog2(D) : 1
) (
   input  logic                         clk,
   input  logic                         rstn_i,
   input  logic [DATA_WIDTH-1:0]        pix_i,
   input  logic                         pix_valid_i,
   output logic                         pix_ready_o,
   input  logic                         conv_done_i,
   output logic [DATA_WIDTH*(W+2)-1:0]  image0_o,
   output logic [DATA_WIDTH*(W+2)-1:0]  image1_o,
   output logic [DATA_WIDTH*(W+2)-1:0]  image2_o,
   output logic                         image_start_o,
   output logic                         frame_done_o
`ifdef CONV_FEEDER_STATUS_EN
   ,
   output logic [RW-1:0]                row_idx_o,
   output logic [CW-1:0]                ch_idx_o,
   output logic                         ovf_o
`endif
);

   localparam int TOTAL = D * H * W;
   localparam int AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam int BW    = DATA_WIDTH * (W + 2);

   localparam logic [AW-1:0] ADDR_LAST = AW'(TOTAL - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(H - 1);
   localparam logic [CW-1:0] CH_LAST   = CW'(D - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                state, state_nx;
   logic [DATA_WIDTH-1:0] mem [TOTAL];
   logic [AW-1:0]         wr_addr;
   logic [RW-1:0]         row, win_row;
   logic [CW-1:0]         ch, win_ch;
   logic                  load_win;
   logic                  wr_en;
   logic [BW-1:0]         win0_nx, win1_nx, win2_nx;

   assign wr_en         = pix_valid_i & pix_ready_o;
   assign image_start_o = (state == S_ISSUE);
   assign frame_done_o  = (state == S_DONE);

   // Buffer read with bypass so the pixel being written this cycle is visible
   // to a window captured on the same edge.
   function automatic logic [DATA_WIDTH-1:0] fetch(input int addr);
      logic [AW-1:0] a;
      a = AW'(addr);
      if (wr_en && (a == wr_addr)) return pix_i;
      return mem[a];
   endfunction

   // State register
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) state <= S_IDLE;
      else         state <= state_nx;
   end

   // Next state and selection of the next window to capture
   always_comb begin
      state_nx = state;
      load_win = 1'b0;
      win_row  = row;
      win_ch   = ch;
      case (state)
         S_IDLE, S_LOAD: begin
            if (wr_en) begin
               if (wr_addr == ADDR_LAST) begin
                  state_nx = S_ISSUE;
                  load_win = 1'b1;
                  win_row  = '0;
                  win_ch   = '0;
               end else begin
                  state_nx = S_LOAD;
               end
            end
         end
         S_ISSUE: state_nx = S_WAIT;
         S_WAIT: begin
            if (conv_done_i) begin
               if ((row == ROW_LAST) && (ch == CH_LAST)) begin
                  state_nx = S_DONE;
               end else begin
                  state_nx = S_ISSUE;
                  load_win = 1'b1;
                  if (ch == CH_LAST) begin
                     win_ch  = '0;
                     win_row = row + 1'b1;
                  end else begin
                     win_ch  = ch + 1'b1;
                  end
               end
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Assemble the padded row buses for the window about to be captured
   always_comb begin
      int base;
      int rr;
      win0_nx = '0;
      win1_nx = '0;
      win2_nx = '0;
      rr      = int'(win_row);
      base    = int'(win_ch) * H * W;
      for (int c = 0; c < W; c++) begin
         if (rr > 0)
            win0_nx[DATA_WIDTH*(c+1) +: DATA_WIDTH] = fetch(base + (rr - 1) * W + c);
         win1_nx[DATA_WIDTH*(c+1) +: DATA_WIDTH] = fetch(base + rr * W + c);
         if (rr < H - 1)
            win2_nx[DATA_WIDTH*(c+1) +: DATA_WIDTH] = fetch(base + (rr + 1) * W + c);
      end
   end

   // Write pointer, window indices, captured window and ready flag
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_addr     <= '0;
         row         <= '0;
         ch          <= '0;
         image0_o    <= '0;
         image1_o    <= '0;
         image2_o    <= '0;
         pix_ready_o <= 1'b0;
      end else begin
         pix_ready_o <= (state_nx == S_IDLE) || (state_nx == S_LOAD);
         if (wr_en)
            wr_addr <= (wr_addr == ADDR_LAST) ? '0 : wr_addr + 1'b1;
         if (load_win) begin
            row      <= win_row;
            ch       <= win_ch;
            image0_o <= win0_nx;
            image1_o <= win1_nx;
            image2_o <= win2_nx;
         end
      end
   end

   // Feature-map storage (contents are don't-care after reset)
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= pix_i;
   end

`ifdef CONV_FEEDER_STATUS_EN
   assign row_idx_o = row;
   assign ch_idx_o  = ch;

   // Sticky flag for pixels offered while a frame is being replayed
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i)
         ovf_o <= 1'b0;
      else if (pix_valid_i && ((state == S_ISSUE) || (state == S_WAIT)))
         ovf_o <= 1'b1;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_row_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_row_feeder
//  Description : Self-checking bench for conv_row_feeder: reset behaviour,
//                frame load with and without gaps, full window replay, ignored
//                acknowledges and pixels, back-to-back frames, mid-frame reset.
//                Status ports are checked when CONV_FEEDER_STATUS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_row_feeder;

   localparam int D  = 4;
   localparam int H  = 6;
   localparam int W  = 6;
   localparam int DW = 8;
   localparam int N  = D * H * W;
   localparam int BW = DW * (W + 2);

   logic          clk = 1'b0;
   logic          rstn_i;
   logic [DW-1:0] pix_i;
   logic          pix_valid_i;
   logic          pix_ready_o;
   logic          conv_done_i;
   logic [BW-1:0] image0_o, image1_o, image2_o;
   logic          image_start_o;
   logic          frame_done_o;
`ifdef CONV_FEEDER_STATUS_EN
   logic [$clog2(H)-1:0] row_idx_o;
   logic [$clog2(D)-1:0] ch_idx_o;
   logic                 ovf_o;
`endif

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] frame [N];

   conv_row_feeder #(.D(D), .H(H), .W(W), .DATA_WIDTH(DW)) dut (
      .clk           (clk),
      .rstn_i        (rstn_i),
      .pix_i         (pix_i),
      .pix_valid_i   (pix_valid_i),
      .pix_ready_o   (pix_ready_o),
      .conv_done_i   (conv_done_i),
      .image0_o      (image0_o),
      .image1_o      (image1_o),
      .image2_o      (image2_o),
      .image_start_o (image_start_o),
      .frame_done_o  (frame_done_o)
`ifdef CONV_FEEDER_STATUS_EN
      ,
      .row_idx_o     (row_idx_o),
      .ch_idx_o      (ch_idx_o),
      .ovf_o         (ovf_o)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected padded bus for channel d, feature-map row 'row' (0 outside map)
   function automatic logic [BW-1:0] exp_row(input int d, input int row);
      logic [BW-1:0] v;
      v = '0;
      if (row >= 0 && row < H)
         for (int c = 0; c < W; c++)
            v[DW*(c+1) +: DW] = frame[d*H*W + row*W + c];
      return v;
   endfunction

   task automatic fill_frame(input bit pattern);
      for (int i = 0; i < N; i++)
         frame[i] = pattern ? DW'(i) : DW'($urandom);
   endtask

   // Stream the first n pixels of the model frame, optionally with random gaps
   task automatic send_pixels(input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         int waited;
         if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
               pix_valid_i = 1'b0;
               tick();
            end
         end
         pix_i       = frame[i];
         pix_valid_i = 1'b1;
         waited      = 0;
         while (!pix_ready_o && waited < 20) begin
            tick();
            waited++;
         end
         if (!pix_ready_o) begin
            chk("ready_timeout", pix_ready_o, 1);
            break;
         end
         tick();
      end
      pix_valid_i = 1'b0;
   endtask

   // Replay all windows of the current frame; entered in the first ISSUE cycle
   task automatic run_windows(input int fixed_dly, input bit poke);
      for (int w = 0; w < H * D; w++) begin
         int r, d, dly;
         r = w / D;
         d = w % D;
         chk("win_start", image_start_o, 1);
         chk("win_img0", image0_o, exp_row(d, r - 1));
         chk("win_img1", image1_o, exp_row(d, r));
         chk("win_img2", image2_o, exp_row(d, r + 1));
`ifdef CONV_FEEDER_STATUS_EN
         chk("win_row_idx", row_idx_o, r);
         chk("win_ch_idx", ch_idx_o, d);
`endif
         if (poke && w == 5) begin
            conv_done_i = 1'b1;
            tick();
            conv_done_i = 1'b0;
            chk("issue_ack_no_start", image_start_o, 0);
            chk("issue_ack_hold", image1_o, exp_row(d, r));
         end else begin
            tick();
         end
         if (poke && w == 7) begin
            pix_i       = 8'hA5;
            pix_valid_i = 1'b1;
            chk("wait_ready_low", pix_ready_o, 0);
            tick();
            pix_valid_i = 1'b0;
`ifdef CONV_FEEDER_STATUS_EN
            chk("wait_ovf", ovf_o, 1);
`endif
         end
         dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 4));
         repeat (dly) tick();
         chk("wait_no_start", image_start_o, 0);
         chk("wait_no_done", frame_done_o, 0);
         chk("wait_hold_img2", image2_o, exp_row(d, r + 1));
         conv_done_i = 1'b1;
         tick();
         conv_done_i = 1'b0;
      end
      chk("done_pulse", frame_done_o, 1);
      chk("done_ready_low", pix_ready_o, 0);
      chk("done_no_start", image_start_o, 0);
      tick();
      chk("idle_done_clear", frame_done_o, 0);
      chk("idle_ready", pix_ready_o, 1);
   endtask

   initial begin
      rstn_i      = 1'b1;
      pix_i       = '0;
      pix_valid_i = 1'b0;
      conv_done_i = 1'b0;
      #1 rstn_i = 1'b0;
      #1;
      chk("rst_ready", pix_ready_o, 0);
      chk("rst_start", image_start_o, 0);
      chk("rst_done", frame_done_o, 0);
      chk("rst_img1", image1_o, 0);
      repeat (3) tick();
      rstn_i = 1'b1;
      tick();
      chk("rel_ready", pix_ready_o, 1);

      // Partial frame, then asynchronous reset in the middle of loading
      fill_frame(1'b0);
      send_pixels(20, 1'b0);
      pix_valid_i = 1'b1;
      #2 rstn_i = 1'b0;
      #1;
      chk("midload_rst_ready", pix_ready_o, 0);
      chk("midload_rst_start", image_start_o, 0);
      chk("midload_rst_img0", image0_o, 0);
      chk("midload_rst_img1", image1_o, 0);
      chk("midload_rst_img2", image2_o, 0);
      chk("midload_rst_done", frame_done_o, 0);
      pix_valid_i = 1'b0;
      tick();
      rstn_i = 1'b1;
      tick();
      chk("midload_rel_ready", pix_ready_o, 1);
`ifdef CONV_FEEDER_STATUS_EN
      chk("rst_ovf", ovf_o, 0);
`endif

      // Frame A: pattern data, no gaps, acks after 3 cycles
      fill_frame(1'b1);
      send_pixels(N, 1'b0);
      chk("a_first_img0", image0_o, 0);
      chk("a_first_img1", image1_o, 64'h00_05_04_03_02_01_00_00);
      chk("a_first_img2", image2_o, 64'h00_0B_0A_09_08_07_06_00);
      run_windows(3, 1'b1);

      // Frame B: random data with gaps, streamed straight after frame A
      fill_frame(1'b0);
      send_pixels(N, 1'b1);
      chk("b_first_start", image_start_o, 1);
      run_windows(-1, 1'b1);

      // Acknowledge while idle must be ignored
      conv_done_i = 1'b1;
      tick();
      conv_done_i = 1'b0;
      chk("idle_ack_no_start", image_start_o, 0);
      chk("idle_ack_no_done", frame_done_o, 0);
      chk("idle_ack_ready", pix_ready_o, 1);

      // Frame C: reset while waiting for an acknowledge
      fill_frame(1'b0);
      send_pixels(N, 1'b1);
      tick();
      chk("c_wait_img1", image1_o, exp_row(0, 0));
      #2 rstn_i = 1'b0;
      #1;
      chk("wait_rst_img0", image0_o, 0);
      chk("wait_rst_img1", image1_o, 0);
      chk("wait_rst_img2", image2_o, 0);
      chk("wait_rst_start", image_start_o, 0);
      chk("wait_rst_ready", pix_ready_o, 0);
`ifdef CONV_FEEDER_STATUS_EN
      chk("wait_rst_ovf", ovf_o, 0);
`endif
      tick();
      rstn_i = 1'b1;
      tick();
      chk("wait_rel_ready", pix_ready_o, 1);

      // Frame D: full frame after the aborted one
      fill_frame(1'b0);
      send_pixels(N, 1'b1);
      run_windows(-1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
